// File: rtl/imm_pkg.sv
// Shared immediate-format codes and the instruction-to-immediate decode function.
// Decode always produces a 64-bit result; narrower users truncate it.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_RSVD  = 3'b111;

  typedef struct packed {
    logic        illegal;
    logic [63:0] imm;
  } imm_dec_t;

  // Sign extension targets 64 bits, so truncating to 32 yields the RV32 result as well.
  function automatic imm_dec_t imm_decode(input logic [31:7] instr, input logic [2:0] src,
                                          input int unsigned xlen);
    imm_dec_t r;
    r.illegal = 1'b0;
    r.imm     = '0;
    case (src)
      IMM_I:     r.imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:     r.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     r.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     r.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                          1'b0};
      IMM_U:     r.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_SHAMT: r.imm = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_ZIMM:  r.imm = {59'b0, instr[19:15]};
      default:   r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready register slice: an output register plus one skid entry.
// in_ready depends only on registered state, breaking the out_ready -> in_ready path.
module imm_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept, drain;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // Skid full implies main full and no accept; refill main from skid on drain.
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, flow-controlled immediate generator: decodes on the input side and
// passes {illegal, imm, tag} through a 2-entry skid slice with 1-cycle latency.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned W = XLEN + TAG_W + 1;

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  imm_dec_t     dec;
  logic [W-1:0] buf_in_data;
  logic [W-1:0] buf_out_data;

  always_comb begin
    dec = imm_decode(in_instr, in_immsrc, XLEN);
  end

  if (XLEN < 64) begin : gen_unused_hi
    logic unused_imm_hi;
    assign unused_imm_hi = ^dec.imm[63:XLEN];
  end

  assign buf_in_data = {dec.illegal, dec.imm[XLEN-1:0], in_tag};

  imm_skid_buf #(
    .W(W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out_data)
  );

  assign out_tag     = buf_out_data[TAG_W-1:0];
  assign out_imm     = buf_out_data[TAG_W +: XLEN];
  assign out_illegal = buf_out_data[W-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm;
  logic [4:0]  r32_out_tag;
  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm;
  logic [4:0]  r64_out_tag;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_out_imm),
    .out_tag(r32_out_tag), .out_illegal(r32_out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_out_imm),
    .out_tag(r64_out_tag), .out_illegal(r64_out_illegal)
  );

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_immsrc = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (r32_out_valid !== 1'b0 || r32_out_imm !== 32'h0 || r32_out_tag !== 5'h0 ||
        r32_out_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset32: got v=%b imm=%h tag=%h ill=%b, expected all zero",
               r32_out_valid, r32_out_imm, r32_out_tag, r32_out_illegal);
    end
    tests_run++;
    if (r64_out_valid !== 1'b0 || r64_out_imm !== 64'h0 || r64_out_tag !== 5'h0 ||
        r64_out_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset64: got v=%b imm=%h tag=%h ill=%b, expected all zero",
               r64_out_valid, r64_out_imm, r64_out_tag, r64_out_illegal);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (r32_in_ready !== 1'b1 || r64_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", r32_in_ready, r64_in_ready);
    end
  endtask

  task automatic test_formats();
    logic [31:0] v_instr [8];
    logic [2:0]  v_src   [8];
    logic [31:0] v_exp32 [8];
    logic [63:0] v_exp64 [8];
    logic [31:0] cur;
    v_instr[0] = 32'hFFF00093; v_src[0] = IMM_I;
    v_exp32[0] = 32'hFFFFFFFF; v_exp64[0] = 64'hFFFFFFFFFFFFFFFF;
    v_instr[1] = 32'hFE512E23; v_src[1] = IMM_S;
    v_exp32[1] = 32'hFFFFFFFC; v_exp64[1] = 64'hFFFFFFFFFFFFFFFC;
    v_instr[2] = 32'h80000063; v_src[2] = IMM_B;
    v_exp32[2] = 32'hFFFFF000; v_exp64[2] = 64'hFFFFFFFFFFFFF000;
    v_instr[3] = 32'h800000EF; v_src[3] = IMM_J;
    v_exp32[3] = 32'hFFF00000; v_exp64[3] = 64'hFFFFFFFFFFF00000;
    v_instr[4] = 32'h12345037; v_src[4] = IMM_U;
    v_exp32[4] = 32'h12345000; v_exp64[4] = 64'h0000000012345000;
    v_instr[5] = 32'h80000037; v_src[5] = IMM_U;
    v_exp32[5] = 32'h80000000; v_exp64[5] = 64'hFFFFFFFF80000000;
    v_instr[6] = 32'h03F00013; v_src[6] = IMM_SHAMT;
    v_exp32[6] = 32'h0000001F; v_exp64[6] = 64'h000000000000003F;
    v_instr[7] = 32'h000F8073; v_src[7] = IMM_ZIMM;
    v_exp32[7] = 32'h0000001F; v_exp64[7] = 64'h000000000000001F;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cur = v_instr[i];
      in_valid = 1'b1; in_instr = cur[31:7]; in_immsrc = v_src[i];
      in_tag = 5'(i + 1); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (r32_out_valid !== 1'b1 || r32_out_imm !== v_exp32[i] || r32_out_illegal !== 1'b0 ||
          r32_out_tag !== 5'(i + 1)) begin
        tests_failed++;
        $display("FAIL fmt32[%0d]: got v=%b imm=%h ill=%b tag=%0d expected v=1 imm=%h ill=0 tag=%0d",
                 i, r32_out_valid, r32_out_imm, r32_out_illegal, r32_out_tag, v_exp32[i], i + 1);
      end
      tests_run++;
      if (r64_out_valid !== 1'b1 || r64_out_imm !== v_exp64[i] || r64_out_illegal !== 1'b0 ||
          r64_out_tag !== 5'(i + 1)) begin
        tests_failed++;
        $display("FAIL fmt64[%0d]: got v=%b imm=%h ill=%b tag=%0d expected v=1 imm=%h ill=0 tag=%0d",
                 i, r64_out_valid, r64_out_imm, r64_out_illegal, r64_out_tag, v_exp64[i], i + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [31:0] cur;
    cur = 32'hFFF00093;
    @(negedge clk);
    in_valid = 1'b1; in_instr = cur[31:7]; in_immsrc = IMM_RSVD; in_tag = 5'd9; out_ready = 1'b1;
    @(negedge clk);
    in_immsrc = IMM_I; in_tag = 5'd10;
    tests_run++;
    if (r32_out_valid !== 1'b1 || r32_out_imm !== 32'h0 || r32_out_illegal !== 1'b1 ||
        r32_out_tag !== 5'd9 || r64_out_imm !== 64'h0 || r64_out_illegal !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsvd: got v=%b imm=%h ill=%b tag=%0d imm64=%h ill64=%b expected 1 0 1 9 0 1",
               r32_out_valid, r32_out_imm, r32_out_illegal, r32_out_tag, r64_out_imm,
               r64_out_illegal);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (r32_out_valid !== 1'b1 || r32_out_imm !== 32'hFFFFFFFF || r32_out_illegal !== 1'b0 ||
        r32_out_tag !== 5'd10) begin
      tests_failed++;
      $display("FAIL after_rsvd: got v=%b imm=%h ill=%b tag=%0d expected 1 ffffffff 0 10",
               r32_out_valid, r32_out_imm, r32_out_illegal, r32_out_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          idx, exp_tag, out_cnt;
    logic        prev_stall, in_fire;
    logic [4:0]  prev_tag;
    logic [31:0] prev_imm;
    logic [11:0] idx12;
    idx = 1; exp_tag = 1; out_cnt = 0; prev_stall = 1'b0; prev_tag = '0; prev_imm = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idx12 = 12'(idx);
      in_valid = (idx <= 8); in_tag = 5'(idx); in_instr = {idx12, 13'd0}; in_immsrc = IMM_I;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (prev_stall) begin
        tests_run++;
        if (r32_out_valid !== 1'b1 || r32_out_tag !== prev_tag || r32_out_imm !== prev_imm) begin
          tests_failed++;
          $display("FAIL hold c=%0d: got v=%b tag=%0d imm=%h expected v=1 tag=%0d imm=%h",
                   c, r32_out_valid, r32_out_tag, r32_out_imm, prev_tag, prev_imm);
        end
      end
      if (c >= 3 && c <= 5) begin
        tests_run++;
        if (r32_in_ready !== (c == 3)) begin
          tests_failed++;
          $display("FAIL stall_in_ready c=%0d: got %b expected %b", c, r32_in_ready, (c == 3));
        end
      end
      if (r32_out_valid && out_ready) begin
        tests_run++;
        if (r32_out_tag !== 5'(exp_tag) || r32_out_imm !== 32'(exp_tag)) begin
          tests_failed++;
          $display("FAIL order: got tag=%0d imm=%h expected tag=%0d imm=%h",
                   r32_out_tag, r32_out_imm, exp_tag, 32'(exp_tag));
        end
        exp_tag++;
        out_cnt++;
      end
      prev_stall = r32_out_valid && !out_ready;
      prev_tag   = r32_out_tag;
      prev_imm   = r32_out_imm;
      in_fire    = in_valid && r32_in_ready;
      @(posedge clk);
      if (in_fire) idx++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_cnt != 8) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d beats expected 8", out_cnt);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_immsrc = IMM_I; in_instr = '0; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (r32_in_ready !== 1'b0 || r32_out_valid !== 1'b1 || r32_out_tag !== 5'd20) begin
      tests_failed++;
      $display("FAIL full: got in_ready=%b v=%b tag=%0d expected 0 1 20",
               r32_in_ready, r32_out_valid, r32_out_tag);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (r32_out_valid !== 1'b0 || r32_out_tag !== 5'd0 || r64_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b tag=%0d v64=%b expected 0 0 0",
               r32_out_valid, r32_out_tag, r64_out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (r32_in_ready !== 1'b1 || r32_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: got in_ready=%b v=%b expected 1 0", r32_in_ready, r32_out_valid);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 5'd22;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (r32_out_valid !== 1'b1 || r32_out_tag !== 5'd22) begin
      tests_failed++;
      $display("FAIL post_reset_beat: got v=%b tag=%0d expected 1 22", r32_out_valid, r32_out_tag);
    end
    @(negedge clk);
    tests_run++;
    if (r32_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_alone: got v=%b expected 0", r32_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
